// File: rtl/hb_pcim_burst_writer_pkg.sv
// cl_manycore_pkg: shared types and constants for the PCIM burst writer.
//   state_e      - writer FSM states (also exported on the debug port)
//   AXI_BURST_*  - AXI4 AWBURST encodings
//   AXI_RESP_*   - AXI4 BRESP encodings
//   burst_bytes  - bytes covered by one burst of len beats of width data_width
package cl_manycore_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [63:0] burst_bytes(input int unsigned len,
                                                input int unsigned data_width);
        return 64'(len) * 64'(data_width / 8);
    endfunction

endpackage

// File: rtl/hb_pcim_burst_writer_if.sv
// AXI4 write-only channel bundle (AW, W, B) for the PCIM port.
// Signal names are given from the master's point of view (_o driven by the
// CL master, _i driven by the host responder).
//   master modport: drives AW/W payloads and bready_o
//   slave  modport: drives awready_i, wready_i and the B channel
// Every channel uses plain AXI valid/ready: a transfer happens on a rising
// clock edge where valid and ready are both high; once valid is raised the
// payload is held until that transfer.
interface hb_pcim_burst_writer_if #(
    parameter int axi_id_width_p   = 6,
    parameter int axi_addr_width_p = 64,
    parameter int axi_data_width_p = 512
);
    logic                          awvalid_o;
    logic                          awready_i;
    logic [axi_addr_width_p-1:0]   awaddr_o;
    logic [axi_id_width_p-1:0]     awid_o;
    logic [7:0]                    awlen_o;
    logic [2:0]                    awsize_o;
    logic [1:0]                    awburst_o;

    logic                          wvalid_o;
    logic                          wready_i;
    logic [axi_data_width_p-1:0]   wdata_o;
    logic [axi_data_width_p/8-1:0] wstrb_o;
    logic                          wlast_o;

    logic                          bvalid_i;
    logic                          bready_o;
    logic [1:0]                    bresp_i;
    logic [axi_id_width_p-1:0]     bid_i;

    modport master (
        output awvalid_o, awaddr_o, awid_o, awlen_o, awsize_o, awburst_o,
        input  awready_i,
        output wvalid_o, wdata_o, wstrb_o, wlast_o,
        input  wready_i,
        input  bvalid_i, bresp_i, bid_i,
        output bready_o
    );

    modport slave (
        input  awvalid_o, awaddr_o, awid_o, awlen_o, awsize_o, awburst_o,
        output awready_i,
        input  wvalid_o, wdata_o, wstrb_o, wlast_o,
        output wready_i,
        output bvalid_i, bresp_i, bid_i,
        input  bready_o
    );

endinterface

// File: rtl/hb_pcim_burst_writer.sv
// hb_pcim_burst_writer: AXI4 write master that copies a data stream into host
// memory as a sequence of fixed-length INCR bursts, one burst outstanding.
// Ports:
//   clk_main_a0, rst_main_n        clock, asynchronous active-low reset
//   start_i, base_addr_i,
//   num_bursts_i                   job request (sampled when accepted in IDLE)
//   data_v_i/data_ready_o/data_i   input stream, forwarded onto W in DATA
//   pcim                           AXI AW/W/B channels (master modport)
//   busy_o, done_o, error_o        job status (error_o sticky until next start)
//   bursts_done_o                  bursts acknowledged OKAY in current/last job
//   perf_cycles_o                  busy-cycle counter
//   state_o                        FSM state, for debug/observation
// Build option: HB_PCIM_WRITER_PERF_EN enables the saturating busy-cycle
// counter; without it perf_cycles_o is tied to zero.
module hb_pcim_burst_writer
    import cl_manycore_pkg::*;
#(
    parameter int                          axi_id_width_p   = 6,
    parameter int                          axi_addr_width_p = 64,
    parameter int                          axi_data_width_p = 512,
    parameter int                          burst_len_p      = 8,
    parameter logic [axi_id_width_p-1:0]   awid_p           = '0
) (
    input  logic                        clk_main_a0,
    input  logic                        rst_main_n,
    input  logic                        start_i,
    input  logic [axi_addr_width_p-1:0] base_addr_i,
    input  logic [15:0]                 num_bursts_i,
    input  logic                        data_v_i,
    output logic                        data_ready_o,
    input  logic [axi_data_width_p-1:0] data_i,
    hb_pcim_burst_writer_if.master      pcim,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [15:0]                 bursts_done_o,
    output logic [31:0]                 perf_cycles_o,
    output state_e                      state_o
);

    localparam logic [axi_addr_width_p-1:0] BURST_BYTES =
        axi_addr_width_p'(burst_bytes(burst_len_p, axi_data_width_p));
    localparam logic [7:0] AWLEN  = 8'(burst_len_p - 1);
    localparam logic [2:0] AWSIZE = 3'($clog2(axi_data_width_p / 8));

    state_e                      state_q, state_d;
    logic [axi_addr_width_p-1:0] addr_q, addr_d;
    logic [15:0]                 remaining_q, remaining_d;
    logic [7:0]                  beat_q, beat_d;
    logic                        error_q, error_d;
    logic [15:0]                 bursts_done_q, bursts_done_d;

    logic is_addr, is_data, is_resp;
    logic w_hs, b_ok;

    assign is_addr = (state_q == ST_ADDR);
    assign is_data = (state_q == ST_DATA);
    assign is_resp = (state_q == ST_RESP);
    assign w_hs    = pcim.wvalid_o && pcim.wready_i;
    // A response only counts as success if it is OKAY and carries our ID.
    assign b_ok    = (pcim.bresp_i == AXI_RESP_OKAY) && (pcim.bid_i == awid_p);

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            beat_q        <= '0;
            error_q       <= 1'b0;
            bursts_done_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            beat_q        <= beat_d;
            error_q       <= error_d;
            bursts_done_q <= bursts_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        beat_d        = beat_q;
        error_d       = error_q;
        bursts_done_d = bursts_done_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d        = base_addr_i;
                    remaining_d   = num_bursts_i;
                    beat_d        = '0;
                    error_d       = 1'b0;
                    bursts_done_d = '0;
                    if (num_bursts_i == 16'd0) begin
                        state_d = ST_DONE;
                    end else if ((base_addr_i % BURST_BYTES) != '0) begin
                        // Burst-size alignment is what keeps each burst
                        // inside one 4 KB page, so refuse anything else.
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (pcim.awready_i) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (beat_q == AWLEN) begin
                        beat_d  = '0;
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_RESP: begin
                if (pcim.bvalid_i) begin
                    if (b_ok) begin
                        bursts_done_d = bursts_done_q + 16'd1;
                        addr_d        = addr_q + BURST_BYTES;
                        remaining_d   = remaining_q - 16'd1;
                        state_d       = (remaining_q == 16'd1) ? ST_DONE : ST_ADDR;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // AW fields are held at zero outside ADDR so the bus is quiet when idle.
    assign pcim.awvalid_o = is_addr;
    assign pcim.awaddr_o  = is_addr ? addr_q : '0;
    assign pcim.awid_o    = is_addr ? awid_p : '0;
    assign pcim.awlen_o   = is_addr ? AWLEN : 8'd0;
    assign pcim.awsize_o  = is_addr ? AWSIZE : 3'd0;
    assign pcim.awburst_o = is_addr ? AXI_BURST_INCR : 2'b00;

    // W is a straight pass-through of the input stream while in DATA.
    assign pcim.wvalid_o  = is_data && data_v_i;
    assign data_ready_o   = is_data && pcim.wready_i;
    assign pcim.wdata_o   = data_i;
    assign pcim.wstrb_o   = is_data ? '1 : '0;
    assign pcim.wlast_o   = is_data && (beat_q == AWLEN);

    assign pcim.bready_o  = is_resp;

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign error_o       = error_q;
    assign bursts_done_o = bursts_done_q;
    assign state_o       = state_q;

`ifdef HB_PCIM_WRITER_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_IDLE) && start_i) begin
            perf_d = '0;
        end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_hb_pcim_burst_writer.sv
// Directed testbench for hb_pcim_burst_writer (burst_len 8, 512-bit data).
// A small responder model drives AW/W/B ready/response per test settings;
// the data source is fed from an expected queue so W ordering is checked.
module tb_hb_pcim_burst_writer;
    import cl_manycore_pkg::*;

    logic clk_main_a0 = 1'b0;
    logic rst_main_n  = 1'b0;
    always #5 clk_main_a0 = ~clk_main_a0;

    logic          start_i;
    logic [63:0]   base_addr_i;
    logic [15:0]   num_bursts_i;
    logic          data_v_i;
    logic          data_ready_o;
    logic [511:0]  data_i;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [15:0]   bursts_done_o;
    logic [31:0]   perf_cycles_o;
    state_e        state_o;

    hb_pcim_burst_writer_if #(
        .axi_id_width_p(6), .axi_addr_width_p(64), .axi_data_width_p(512)
    ) pcim_if ();

    hb_pcim_burst_writer #(
        .axi_id_width_p(6), .axi_addr_width_p(64), .axi_data_width_p(512),
        .burst_len_p(8), .awid_p(6'd0)
    ) dut (
        .clk_main_a0   (clk_main_a0),
        .rst_main_n    (rst_main_n),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .num_bursts_i  (num_bursts_i),
        .data_v_i      (data_v_i),
        .data_ready_o  (data_ready_o),
        .data_i        (data_i),
        .pcim          (pcim_if),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .bursts_done_o (bursts_done_o),
        .perf_cycles_o (perf_cycles_o),
        .state_o       (state_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Per-job observations filled in by run_job.
    logic [63:0]  aw_q[$];
    logic [511:0] exp_q[$];
    int beat_cnt, done_cnt, done_cyc, bad_last, bad_data, bad_aw, aw_unstable;
    logic busy_after;
    bit   timed_out;

    task automatic idle_inputs();
        start_i            = 1'b0;
        data_v_i           = 1'b0;
        data_i             = '0;
        pcim_if.awready_i  = 1'b0;
        pcim_if.wready_i   = 1'b0;
        pcim_if.bvalid_i   = 1'b0;
        pcim_if.bresp_i    = 2'b00;
        pcim_if.bid_i      = '0;
    endtask

    // Runs one job to completion. aw_stall: cycles awready is held low per AW;
    // rand_w/gaps: random wready and data_v_i; err_burst: index of burst whose
    // B is SLVERR (-1 none); spur_cyc: cycle at which start_i is re-pulsed.
    task automatic run_job(input logic [63:0] base, input logic [15:0] nb,
                           input int aw_stall, input bit rand_w, input bit gaps,
                           input int err_burst, input int spur_cyc, input int budget);
        int cyc, stall, bcnt;
        logic [63:0] held;
        bit holding, fin;
        logic [31:0] sb;
        sb = $urandom;
        aw_q.delete();
        exp_q.delete();
        for (int k = 0; k < int'(nb) * 8; k++) exp_q.push_back({16{sb + 32'(k)}});
        beat_cnt = 0; done_cnt = 0; done_cyc = -1; bad_last = 0; bad_data = 0;
        bad_aw = 0; aw_unstable = 0; timed_out = 0; busy_after = 1'bx;
        stall = 0; bcnt = 0; holding = 0; fin = 0; held = '0;
        @(negedge clk_main_a0);
        start_i = 1'b1; base_addr_i = base; num_bursts_i = nb;
        @(negedge clk_main_a0);
        start_i = 1'b0;
        cyc = 1;
        while (!fin) begin
            if (cyc == spur_cyc) begin
                start_i = 1'b1; base_addr_i = 64'h8000; num_bursts_i = 16'd5;
            end else begin
                start_i = 1'b0;
            end
            pcim_if.awready_i = pcim_if.awvalid_o && (stall >= aw_stall);
            pcim_if.wready_i  = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
            data_v_i          = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_i            = (exp_q.size() > 0) ? exp_q[0] : '0;
            pcim_if.bvalid_i  = pcim_if.bready_o;
            pcim_if.bresp_i   = (bcnt == err_burst) ? 2'b10 : 2'b00;
            pcim_if.bid_i     = '0;
            #1;
            if (pcim_if.awvalid_o) begin
                if (holding && (pcim_if.awaddr_o !== held)) aw_unstable++;
                if (pcim_if.awlen_o !== 8'd7 || pcim_if.awsize_o !== 3'd6 ||
                    pcim_if.awburst_o !== 2'b01 || pcim_if.awid_o !== 6'd0) bad_aw++;
                if (pcim_if.awready_i) begin
                    aw_q.push_back(pcim_if.awaddr_o);
                    holding = 0; stall = 0;
                end else begin
                    holding = 1; held = pcim_if.awaddr_o; stall++;
                end
            end
            if (pcim_if.wvalid_o && pcim_if.wready_i) begin
                if (exp_q.size() == 0) begin
                    bad_data++;
                end else begin
                    if (pcim_if.wdata_o !== exp_q[0]) bad_data++;
                    void'(exp_q.pop_front());
                end
                if (pcim_if.wlast_o !== ((beat_cnt % 8) == 7)) bad_last++;
                if (pcim_if.wstrb_o !== {64{1'b1}}) bad_last++;
                beat_cnt++;
            end
            if (pcim_if.bvalid_i && pcim_if.bready_o) bcnt++;
            if (done_cnt > 0) begin
                busy_after = busy_o;
                fin = 1;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc >= budget) begin
                timed_out = 1;
                fin = 1;
            end
            @(negedge clk_main_a0);
            cyc++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        vectors++; if (pcim_if.awvalid_o !== 1'b0) begin miscompares++; $display("FAIL reset_awvalid got %b exp 0", pcim_if.awvalid_o); end
        vectors++; if (pcim_if.wvalid_o !== 1'b0) begin miscompares++; $display("FAIL reset_wvalid got %b exp 0", pcim_if.wvalid_o); end
        vectors++; if (pcim_if.bready_o !== 1'b0) begin miscompares++; $display("FAIL reset_bready got %b exp 0", pcim_if.bready_o); end
        vectors++; if (data_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_data_ready got %b exp 0", data_ready_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        vectors++; if (done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done_o); end
        vectors++; if (error_o !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b exp 0", error_o); end
        vectors++; if (bursts_done_o !== 16'd0) begin miscompares++; $display("FAIL reset_bursts_done got %0d exp 0", bursts_done_o); end
        vectors++; if (perf_cycles_o !== 32'd0) begin miscompares++; $display("FAIL reset_perf got %0d exp 0", perf_cycles_o); end
        vectors++; if (pcim_if.awaddr_o !== 64'd0) begin miscompares++; $display("FAIL reset_awaddr got %0h exp 0", pcim_if.awaddr_o); end
        vectors++; if (pcim_if.awlen_o !== 8'd0) begin miscompares++; $display("FAIL reset_awlen got %0d exp 0", pcim_if.awlen_o); end
    endtask

    task automatic test_basic();
        run_job(64'h1000, 16'd2, 0, 0, 0, -1, -1, 200);
        vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL basic_timeout got %b exp 0", timed_out); end
        vectors++; if (aw_q.size() !== 2) begin miscompares++; $display("FAIL basic_aw_count got %0d exp 2", aw_q.size()); end
        if (aw_q.size() == 2) begin
            vectors++; if (aw_q[0] !== 64'h1000) begin miscompares++; $display("FAIL basic_aw0 got %0h exp 1000", aw_q[0]); end
            vectors++; if (aw_q[1] !== 64'h1200) begin miscompares++; $display("FAIL basic_aw1 got %0h exp 1200", aw_q[1]); end
        end
        vectors++; if (bad_aw !== 0) begin miscompares++; $display("FAIL basic_aw_fields got %0d bad exp 0", bad_aw); end
        vectors++; if (beat_cnt !== 16) begin miscompares++; $display("FAIL basic_beats got %0d exp 16", beat_cnt); end
        vectors++; if (bad_last !== 0) begin miscompares++; $display("FAIL basic_wlast got %0d bad exp 0", bad_last); end
        vectors++; if (bad_data !== 0) begin miscompares++; $display("FAIL basic_data got %0d bad exp 0", bad_data); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
        vectors++; if (done_cyc !== 21) begin miscompares++; $display("FAIL basic_done_cycle got %0d exp 21", done_cyc); end
        vectors++; if (busy_after !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got %b exp 0", busy_after); end
        vectors++; if (bursts_done_o !== 16'd2) begin miscompares++; $display("FAIL basic_bursts_done got %0d exp 2", bursts_done_o); end
        vectors++; if (error_o !== 1'b0) begin miscompares++; $display("FAIL basic_error got %b exp 0", error_o); end
    endtask

    task automatic test_stall();
        run_job(64'h2000, 16'd2, 5, 1, 1, -1, -1, 600);
        vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL stall_timeout got %b exp 0", timed_out); end
        vectors++; if (aw_unstable !== 0) begin miscompares++; $display("FAIL stall_aw_stable got %0d changes exp 0", aw_unstable); end
        vectors++; if (aw_q.size() !== 2) begin miscompares++; $display("FAIL stall_aw_count got %0d exp 2", aw_q.size()); end
        if (aw_q.size() == 2) begin
            vectors++; if (aw_q[1] !== 64'h2200) begin miscompares++; $display("FAIL stall_aw1 got %0h exp 2200", aw_q[1]); end
        end
        vectors++; if (beat_cnt !== 16) begin miscompares++; $display("FAIL stall_beats got %0d exp 16", beat_cnt); end
        vectors++; if (bad_data !== 0) begin miscompares++; $display("FAIL stall_data got %0d bad exp 0", bad_data); end
        vectors++; if (bad_last !== 0) begin miscompares++; $display("FAIL stall_wlast got %0d bad exp 0", bad_last); end
        vectors++; if (bursts_done_o !== 16'd2) begin miscompares++; $display("FAIL stall_bursts_done got %0d exp 2", bursts_done_o); end
    endtask

    task automatic test_slverr();
        run_job(64'h4000, 16'd4, 0, 0, 0, 1, -1, 300);
        vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL slverr_timeout got %b exp 0", timed_out); end
        vectors++; if (aw_q.size() !== 2) begin miscompares++; $display("FAIL slverr_aw_count got %0d exp 2", aw_q.size()); end
        vectors++; if (error_o !== 1'b1) begin miscompares++; $display("FAIL slverr_error got %b exp 1", error_o); end
        vectors++; if (bursts_done_o !== 16'd1) begin miscompares++; $display("FAIL slverr_bursts_done got %0d exp 1", bursts_done_o); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL slverr_done_count got %0d exp 1", done_cnt); end
    endtask

    task automatic test_zero_and_misaligned();
        run_job(64'h1000, 16'd0, 0, 0, 0, -1, -1, 50);
        vectors++; if (aw_q.size() !== 0) begin miscompares++; $display("FAIL zero_aw_count got %0d exp 0", aw_q.size()); end
        vectors++; if (done_cyc !== 1) begin miscompares++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc); end
        vectors++; if (error_o !== 1'b0) begin miscompares++; $display("FAIL zero_error got %b exp 0", error_o); end
        vectors++; if (bursts_done_o !== 16'd0) begin miscompares++; $display("FAIL zero_bursts_done got %0d exp 0", bursts_done_o); end
        run_job(64'h1040, 16'd2, 0, 0, 0, -1, -1, 50);
        vectors++; if (aw_q.size() !== 0) begin miscompares++; $display("FAIL misaligned_aw_count got %0d exp 0", aw_q.size()); end
        vectors++; if (done_cyc !== 1) begin miscompares++; $display("FAIL misaligned_done_cycle got %0d exp 1", done_cyc); end
        vectors++; if (error_o !== 1'b1) begin miscompares++; $display("FAIL misaligned_error got %b exp 1", error_o); end
    endtask

    task automatic test_start_while_busy();
        run_job(64'h3000, 16'd1, 0, 0, 0, -1, 4, 200);
        vectors++; if (aw_q.size() !== 1) begin miscompares++; $display("FAIL spur_aw_count got %0d exp 1", aw_q.size()); end
        if (aw_q.size() == 1) begin
            vectors++; if (aw_q[0] !== 64'h3000) begin miscompares++; $display("FAIL spur_aw0 got %0h exp 3000", aw_q[0]); end
        end
        vectors++; if (bursts_done_o !== 16'd1) begin miscompares++; $display("FAIL spur_bursts_done got %0d exp 1", bursts_done_o); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL spur_done_count got %0d exp 1", done_cnt); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL spur_idle_after got %b exp 0", busy_o); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk_main_a0);
        start_i = 1'b1; base_addr_i = 64'h5000; num_bursts_i = 16'd2;
        pcim_if.awready_i = 1'b1; pcim_if.wready_i = 1'b1; data_v_i = 1'b1;
        @(negedge clk_main_a0);
        start_i = 1'b0;
        @(negedge clk_main_a0);
        @(negedge clk_main_a0);
        vectors++; if (pcim_if.wvalid_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_data got %b exp 1", pcim_if.wvalid_o); end
        rst_main_n = 1'b0;
        #1;
        vectors++; if (pcim_if.awvalid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_awvalid got %b exp 0", pcim_if.awvalid_o); end
        vectors++; if (pcim_if.wvalid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_wvalid got %b exp 0", pcim_if.wvalid_o); end
        vectors++; if (data_ready_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_data_ready got %b exp 0", data_ready_o); end
        vectors++; if (pcim_if.bready_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_bready got %b exp 0", pcim_if.bready_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b exp 0", busy_o); end
        @(negedge clk_main_a0);
        idle_inputs();
        rst_main_n = 1'b1;
        run_job(64'h5000, 16'd1, 0, 0, 0, -1, -1, 200);
        vectors++; if (aw_q.size() !== 1) begin miscompares++; $display("FAIL rstmid_rerun_aw got %0d exp 1", aw_q.size()); end
        vectors++; if (beat_cnt !== 8) begin miscompares++; $display("FAIL rstmid_rerun_beats got %0d exp 8", beat_cnt); end
        vectors++; if (bad_data !== 0) begin miscompares++; $display("FAIL rstmid_rerun_data got %0d bad exp 0", bad_data); end
        vectors++; if (bursts_done_o !== 16'd1) begin miscompares++; $display("FAIL rstmid_rerun_bursts got %0d exp 1", bursts_done_o); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_perf;
`ifdef HB_PCIM_WRITER_PERF_EN
        exp_perf = 32'd11;
`else
        exp_perf = 32'd0;
`endif
        run_job(64'h0, 16'd1, 0, 0, 0, -1, -1, 100);
        vectors++; if (done_cyc !== 11) begin miscompares++; $display("FAIL perf_done_cycle got %0d exp 11", done_cyc); end
        vectors++; if (perf_cycles_o !== exp_perf) begin miscompares++; $display("FAIL perf_cycles got %0d exp %0d", perf_cycles_o, exp_perf); end
    endtask

    initial begin
        idle_inputs();
        base_addr_i  = '0;
        num_bursts_i = '0;
        rst_main_n   = 1'b0;
        repeat (3) @(negedge clk_main_a0);
        test_reset();
        rst_main_n = 1'b1;
        test_basic();
        test_stall();
        test_slverr();
        test_zero_and_misaligned();
        test_start_while_busy();
        test_reset_mid_burst();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
